alu_share_arb: RTL

Round-robin arbiter that time-shares one core alu instance between N_REQ requesters, for example the issue stage, the branch-compare path and the address generator. Each requester presents operands and an alu_op_t over a valid/ready channel. The winner's operation is executed and its result is registered into a single-entry response buffer tagged with the requester ID. Sits between the pipeline front end and the shared execute resource.

---
 rtl/alu_ops_pkg.sv | 30 +++
 rtl/alu.sv | 38 +++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/alu_share_arb.sv | 122 ++++++++++++
 4 files changed

// File: rtl/alu_ops_pkg.sv
// ---------------------------------------------------------------------------
// alu_ops_pkg
// Shared ALU operation encoding and request record used by the ALU and by the
// shared-ALU arbiter. Operation codes 10..15 are unused; the ALU returns 0 for
// them.
// ---------------------------------------------------------------------------
package alu_ops_pkg;

   localparam int ALU_ARB_MAX_REQ = 8;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_t;

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      alu_op_t     op;
   } alu_req_t;

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Purely combinational 32-bit integer ALU.
// Ports:
//   op1_i, op2_i : operands (shift amount taken from op2_i[4:0])
//   op_i         : operation (alu_op_t)
//   res_o        : result, 0 for unknown operation codes
// ---------------------------------------------------------------------------
module alu
   import alu_ops_pkg::*;
(
   input  logic [31:0] op1_i,
   input  logic [31:0] op2_i,
   input  alu_op_t     op_i,
   output logic [31:0] res_o
);

   logic [4:0] shamt;
   assign shamt = op2_i[4:0];

   always_comb begin
      res_o = '0;
      case (op_i)
         ALU_ADD:  res_o = op1_i + op2_i;
         ALU_SUB:  res_o = op1_i - op2_i;
         ALU_AND:  res_o = op1_i & op2_i;
         ALU_OR:   res_o = op1_i | op2_i;
         ALU_XOR:  res_o = op1_i ^ op2_i;
         ALU_SLL:  res_o = op1_i << shamt;
         ALU_SRL:  res_o = op1_i >> shamt;
         ALU_SRA:  res_o = $unsigned($signed(op1_i) >>> shamt);
         ALU_SLT:  res_o = {31'd0, $signed(op1_i) < $signed(op2_i)};
         ALU_SLTU: res_o = {31'd0, op1_i < op2_i};
         default:  res_o = '0;
      endcase
   end

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter with a registered priority pointer.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : request vector
//   advance_i    : current grant was taken; move pointer past the winner
//   gnt_o        : one-hot grant (zero when no request)
//   gnt_idx_o    : index of the granted request
//   gnt_any_o    : some request is granted
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [N-1:0]  req_i,
   input  logic          advance_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] gnt_idx_o,
   output logic          gnt_any_o
);

   logic [IW-1:0] rr_ptr_q, rr_ptr_d;

   // Scan from rr_ptr upward, wrapping; the first asserted request wins.
   always_comb begin
      int  idx;
      logic found;
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(rr_ptr_q) + k) % N;
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = IW'(idx);
         end
      end
      gnt_any_o = found;
   end

   assign rr_ptr_d = (int'(gnt_idx_o) == N - 1) ? '0 : gnt_idx_o + 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i)          rr_ptr_q <= '0;
      else if (advance_i) rr_ptr_q <= rr_ptr_d;
   end

endmodule

// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb
// Time-shares one ALU between N_REQ requesters. A round-robin winner is
// executed and its result captured in a single-entry response buffer tagged
// with the requester index. Drain and refill may happen in the same cycle.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready one-hot or zero)
//   req_op1/op2/op      : per-requester operands and operation
//   rsp_valid/rsp_ready : response handshake
//   rsp_result, rsp_id  : registered result and originating requester
//   perf_grant_cnt, perf_stall_cnt : only with ALU_ARB_PERF_EN defined
// Optional feature macro: ALU_ARB_PERF_EN
// ---------------------------------------------------------------------------
module alu_share_arb
   import alu_ops_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ-1:0][31:0] req_op1,
   input  logic [N_REQ-1:0][31:0] req_op2,
   input  alu_op_t [N_REQ-1:0]    req_op,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [31:0]            rsp_result,
`ifdef ALU_ARB_PERF_EN
   output logic [N_REQ-1:0][31:0] perf_grant_cnt,
   output logic [31:0]            perf_stall_cnt,
`endif
   output logic [ID_W-1:0]        rsp_id
);

   localparam logic [0:0] S_EMPTY = 1'b0;
   localparam logic [0:0] S_FULL  = 1'b1;

   logic [0:0]      state_q, state_d;
   logic [31:0]     res_q, res_d;
   logic [ID_W-1:0] id_q, id_d;

   alu_req_t [N_REQ-1:0] req_s;
   logic [N_REQ-1:0]     gnt;
   logic [ID_W-1:0]      gnt_idx;
   logic                 gnt_any;
   logic                 can_accept;
   logic                 advance;
   logic [31:0]          alu_res;

   for (genvar i = 0; i < N_REQ; i++) begin : g_pack
      assign req_s[i] = '{op1: req_op1[i], op2: req_op2[i], op: req_op[i]};
   end

   assign can_accept = (state_q == S_EMPTY) | rsp_ready;
   // No grant while reset is asserted: reset wins, so the request would be lost.
   assign advance    = can_accept & gnt_any & ~rst;
   assign req_ready  = advance ? gnt : '0;

   rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req_valid),
      .advance_i (advance),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_any_o (gnt_any)
   );

   alu u_alu (
      .op1_i (req_s[gnt_idx].op1),
      .op2_i (req_s[gnt_idx].op2),
      .op_i  (req_s[gnt_idx].op),
      .res_o (alu_res)
   );

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      id_d    = id_q;
      if (advance) begin
         state_d = S_FULL;
         res_d   = alu_res;
         id_d    = gnt_idx;
      end else if (state_q == S_FULL && rsp_ready) begin
         state_d = S_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         res_q   <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         id_q    <= id_d;
      end
   end

   assign rsp_valid  = (state_q == S_FULL);
   assign rsp_result = res_q;
   assign rsp_id     = id_q;

`ifdef ALU_ARB_PERF_EN
   for (genvar i = 0; i < N_REQ; i++) begin : g_perf
      always_ff @(posedge clk) begin
         if (rst)               perf_grant_cnt[i] <= '0;
         else if (req_ready[i]) perf_grant_cnt[i] <= perf_grant_cnt[i] + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                           perf_stall_cnt <= '0;
      else if (|req_valid && !can_accept) perf_stall_cnt <= perf_stall_cnt + 32'd1;
   end
`endif

endmodule
